oam_dma_ctrl: RTL and testbench

Sprite-DMA controller and bus arbiter between the 6502 core and system memory. A CPU write to the trigger address starts a transfer: the controller stalls the CPU via `cpu_rdy`, takes over the memory bus, and copies one 256-byte page to the OAM data port. It then returns the bus to the CPU. It sits between `cpu_top` and `mem` and owns the address, write-data and write-enable lines into memory.

---
 rtl/oam_dma_ctrl_pkg.sv | 18 +
 rtl/oam_dma_ctrl.sv | 93 +++++++++
 tb/tb_oam_dma_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_ctrl_pkg.sv
// Shared types and constants for the sprite-DMA controller.
package oam_dma_ctrl_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    localparam logic [15:0] OAM_DMA_TRIG  = 16'h4014;
    localparam logic [15:0] OAM_DATA_PORT = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA controller: stalls the CPU, copies one 256-byte page to the OAM
// data port through alternating READ/WRITE cycles, then hands the bus back.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = BUS_ADDR_W,
    parameter int                    DATA_WIDTH = BUS_DATA_W,
    parameter logic [ADDR_WIDTH-1:0] TRIG_ADDR  = ADDR_WIDTH'(OAM_DMA_TRIG),
    parameter logic [ADDR_WIDTH-1:0] OAM_ADDR   = ADDR_WIDTH'(OAM_DATA_PORT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_dout,
    input  logic                  cpu_we,
    output logic                  cpu_rdy,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_dout,
    output logic                  bus_we,
    input  logic [DATA_WIDTH-1:0] bus_din,
    output logic                  dma_busy,
    output logic                  dma_done
);

    dma_state_t            state;
    logic [DATA_WIDTH-1:0] page;
    logic [7:0]            cnt;
    logic                  parity;

    always_ff @(posedge clk) begin
        parity   <= ~parity;
        dma_done <= 1'b0;
        if (reset) begin
            state    <= ST_IDLE;
            page     <= '0;
            cnt      <= '0;
            parity   <= 1'b0;
            dma_busy <= 1'b0;
            cpu_rdy  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_we && cpu_addr == TRIG_ADDR) begin
                        page     <= cpu_dout;
                        cnt      <= '0;
                        state    <= ST_HALT;
                        dma_busy <= 1'b1;
                        cpu_rdy  <= 1'b0;
                    end
                end
                // an odd halt cycle needs one extra cycle to line up the read/write pairs
                ST_HALT:  state <= parity ? ST_ALIGN : ST_READ;
                ST_ALIGN: state <= ST_READ;
                ST_READ: begin
                    state    <= ST_WRITE;
                    dma_done <= (cnt == 8'hFF);
                end
                ST_WRITE: begin
                    if (cnt == 8'hFF) begin
                        state    <= ST_IDLE;
                        dma_busy <= 1'b0;
                        cpu_rdy  <= 1'b1;
                    end else begin
                        cnt   <= cnt + 8'd1;
                        state <= ST_READ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // memory data arrives one cycle after the READ address, i.e. during WRITE
    always_comb begin
        bus_addr = cpu_addr;
        bus_dout = cpu_dout;
        bus_we   = cpu_we;
        case (state)
            ST_IDLE: ;
            ST_WRITE: begin
                bus_addr = OAM_ADDR;
                bus_dout = bus_din;
                bus_we   = 1'b1;
            end
            default: begin
                bus_addr = ADDR_WIDTH'({page, cnt});
                bus_dout = '0;
                bus_we   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: pass-through vectors plus scoreboarded DMA transfers.
module tb_oam_dma_ctrl;
    import oam_dma_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_we = 1'b0;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_we;
    logic [7:0]  bus_din = 8'h00;
    logic        dma_busy;
    logic        dma_done;

    always #5 clk = ~clk;

    oam_dma_ctrl #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .TRIG_ADDR(16'h4014), .OAM_ADDR(16'h2004)
    ) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_we(cpu_we), .cpu_rdy(cpu_rdy), .bus_addr(bus_addr), .bus_dout(bus_dout),
        .bus_we(bus_we), .bus_din(bus_din), .dma_busy(dma_busy), .dma_done(dma_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr = 0;
    int n_done = 0;
    int bad_src = 0;
    logic [15:0] last_src = 16'h0000;
    logic [7:0]  exp_page = 8'h00;
    logic [7:0]  exp_q[$];
    logic [15:0] cap_addr = 16'h0000;
    logic        tb_par = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // source memory: content depends on both address bytes so pages are distinguishable
    function automatic logic [7:0] rom(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h58;
    endfunction

    always @(negedge clk) cap_addr <= bus_addr;
    always @(posedge clk) bus_din <= rom(cap_addr);
    always @(posedge clk) tb_par <= reset ? 1'b0 : ~tb_par;

    // scoreboard sink: every write to the OAM port must match the next queued byte
    always @(negedge clk) begin
        if (bus_we && bus_addr == 16'h2004) begin
            n_wr++;
            if (exp_q.size() == 0) check("unexpected_oam_write", 32'(bus_dout), 32'hDEAD);
            else check("oam_data", 32'(bus_dout), 32'(exp_q.pop_front()));
        end
        if (dma_busy && !bus_we) begin
            if (bus_addr[15:8] != exp_page) bad_src++;
            last_src <= bus_addr;
        end
        if (dma_done) begin
            n_done++;
            check("done_on_write", 32'(bus_we && bus_addr == 16'h2004), 32'd1);
        end
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        we;
        logic [15:0] e_addr;
        logic [7:0]  e_dout;
        logic        e_we;
        logic        e_rdy;
    } vec_t;

    vec_t vt[6];

    task automatic do_dma(input logic [7:0] pg, input bit odd, input bit mid_trig, input int rst_at);
        int stall;
        int c;
        int wr0;
        int first_rd;
        @(posedge clk); #1;
        while (tb_par != (odd ? 1'b0 : 1'b1)) begin
            @(posedge clk); #1;
        end
        exp_page = pg;
        for (int i = 0; i < 256; i++) exp_q.push_back(8'(i) ^ pg ^ 8'h58);
        wr0 = n_wr;
        n_done = 0;
        bad_src = 0;
        first_rd = odd ? 3 : 2;
        cpu_addr = 16'h4014; cpu_dout = pg; cpu_we = 1'b1;
        @(posedge clk); #1;
        cpu_addr = 16'h1234; cpu_dout = 8'hEE; cpu_we = 1'b0;
        stall = 0;
        c = 1;
        while (1) begin
            @(negedge clk);
            if (cpu_rdy) break;
            stall++;
            if (c == first_rd) begin
                check("first_read_addr", 32'(bus_addr), 32'({pg, 8'h00}));
                check("first_read_we", 32'(bus_we), 32'd0);
            end
            if (c == first_rd + 1) check("first_write_we", 32'(bus_we), 32'd1);
            if (mid_trig && c == 50) begin
                cpu_addr = 16'h4014; cpu_dout = 8'h03; cpu_we = 1'b1;
            end
            if (mid_trig && c == 60) begin
                cpu_addr = 16'h1234; cpu_dout = 8'hEE; cpu_we = 1'b0;
            end
            if (rst_at > 0 && c == (odd ? 2 : 1) + 2 * rst_at) reset = 1'b1;
            c++;
            if (c > 2000) begin
                check("dma_timeout", 32'(c), 32'd0);
                break;
            end
        end
        if (rst_at > 0) begin
            check("rst_rdy", 32'(cpu_rdy), 32'd1);
            check("rst_busy", 32'(dma_busy), 32'd0);
            check("rst_pass_addr", 32'(bus_addr), 32'h1234);
            check("rst_pass_dout", 32'(bus_dout), 32'hEE);
            check("rst_pass_we", 32'(bus_we), 32'd0);
            check("rst_writes", 32'(n_wr - wr0), 32'(rst_at));
            @(posedge clk); #1;
            reset = 1'b0;
            exp_q.delete();
            repeat (20) @(posedge clk);
            @(negedge clk);
            check("rst_no_more_writes", 32'(n_wr - wr0), 32'(rst_at));
            check("rst_still_idle", 32'(cpu_rdy), 32'd1);
        end else begin
            check("stall_len", 32'(stall), odd ? 32'd514 : 32'd513);
            check("write_count", 32'(n_wr - wr0), 32'd256);
            check("done_pulses", 32'(n_done), 32'd1);
            check("queue_empty", 32'(exp_q.size()), 32'd0);
            check("src_in_page", 32'(bad_src), 32'd0);
            check("last_src", 32'(last_src), 32'({pg, 8'hFF}));
            check("resume_pass_addr", 32'(bus_addr), 32'h1234);
            check("resume_busy", 32'(dma_busy), 32'd0);
        end
    endtask

    initial begin
        vt[0] = '{16'h4013, 8'hA5, 1'b1, 16'h4013, 8'hA5, 1'b1, 1'b1};
        vt[1] = '{16'h4015, 8'h3C, 1'b1, 16'h4015, 8'h3C, 1'b1, 1'b1};
        vt[2] = '{16'h4014, 8'h77, 1'b0, 16'h4014, 8'h77, 1'b0, 1'b1};
        vt[3] = '{16'h0000, 8'h00, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1};
        vt[4] = '{16'hFFFF, 8'hFF, 1'b0, 16'hFFFF, 8'hFF, 1'b0, 1'b1};
        vt[5] = '{16'h2003, 8'h81, 1'b1, 16'h2003, 8'h81, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1 cpu_addr = 16'h4013; cpu_dout = 8'h11; cpu_we = 1'b1;
        @(negedge clk);
        check("reset_rdy", 32'(cpu_rdy), 32'd1);
        check("reset_busy", 32'(dma_busy), 32'd0);
        check("reset_done", 32'(dma_done), 32'd0);
        check("reset_pass_addr", 32'(bus_addr), 32'h4013);
        @(posedge clk); #1;
        reset = 1'b0;
        cpu_we = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            cpu_addr = vt[i].addr; cpu_dout = vt[i].dout; cpu_we = vt[i].we;
            @(negedge clk);
            check("vec_addr", 32'(bus_addr), 32'(vt[i].e_addr));
            check("vec_dout", 32'(bus_dout), 32'(vt[i].e_dout));
            check("vec_we", 32'(bus_we), 32'(vt[i].e_we));
            check("vec_rdy", 32'(cpu_rdy), 32'(vt[i].e_rdy));
        end
        @(posedge clk); #1;
        cpu_we = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("vec_no_dma", 32'(dma_busy), 32'd0);
        check("vec_no_oam_writes", 32'(n_wr), 32'd0);

        do_dma(8'h02, 1'b0, 1'b0, 0);
        do_dma(8'h02, 1'b1, 1'b0, 0);
        do_dma(8'hFF, 1'b0, 1'b0, 0);
        do_dma(8'h02, 1'b0, 1'b1, 0);
        do_dma(8'h02, 1'b0, 1'b0, 100);

        // trigger write coincident with reset must not start a transfer
        @(posedge clk); #1;
        reset = 1'b1; cpu_addr = 16'h4014; cpu_dout = 8'h05; cpu_we = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000;
        @(negedge clk);
        check("trig_in_reset_rdy", 32'(cpu_rdy), 32'd1);
        @(negedge clk);
        check("trig_in_reset_busy", 32'(dma_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
